// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: opcodes, FSM encoding and word step.
package stack_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam int WORD_STEP = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // CALL behaves as PUSH and RET as POP; only the opcode differs.
  function automatic logic is_write_op(input logic [1:0] op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/sp_update.sv
// Stack pointer arithmetic and full/empty detection for a full-descending stack.
module sp_update
  import stack_pkg::*;
#(
  parameter int           W        = 16,
  parameter logic [W-1:0] SP_INIT  = 16'h1000,
  parameter logic [W-1:0] SP_LIMIT = 16'h0E00
) (
  input  logic [W-1:0] sp,
  output logic [W-1:0] sp_inc,
  output logic [W-1:0] sp_dec,
  output logic         full,
  output logic         empty
);

  assign sp_inc = sp + W'(WORD_STEP);
  assign sp_dec = sp - W'(WORD_STEP);
  assign full   = (sp == SP_LIMIT);
  assign empty  = (sp == SP_INIT);

endmodule

// File: rtl/stack_ctrl.sv
// Stack sequencer: sole owner of SP, bounds checking and the single memory access per command.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int           W        = 16,
  parameter logic [W-1:0] SP_INIT  = 16'h1000,
  parameter logic [W-1:0] SP_LIMIT = 16'h0E00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic         done,
  output logic         err,
  output logic [W-1:0] rd_data,
  output logic [W-1:0] sp,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack
);

  state_t       state_r, state_s;
  logic [W-1:0] sp_r, sp_s;
  logic [W-1:0] rd_data_r, rd_data_s;
  logic         done_r, done_s;
  logic         err_r, err_s;
  logic         mem_req_r, mem_req_s;
  logic         mem_we_r, mem_we_s;
  logic [W-1:0] mem_addr_r, mem_addr_s;
  logic [W-1:0] mem_wdata_r, mem_wdata_s;

  logic [W-1:0] sp_inc_s, sp_dec_s;
  logic         full_s, empty_s;

  sp_update #(
    .W        (W),
    .SP_INIT  (SP_INIT),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp_update (
    .sp     (sp_r),
    .sp_inc (sp_inc_s),
    .sp_dec (sp_dec_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  // Next-state and next-output logic; memory request fields stay stable until ack.
  always_comb begin
    state_s     = state_r;
    sp_s        = sp_r;
    rd_data_s   = rd_data_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_write_op(cmd_op)) begin
            if (full_s) begin
              state_s = ST_ERR;
              done_s  = 1'b1;
              err_s   = 1'b1;
            end else begin
              state_s     = ST_WRITE;
              mem_req_s   = 1'b1;
              mem_we_s    = 1'b1;
              mem_addr_s  = sp_dec_s;
              mem_wdata_s = cmd_data;
            end
          end else begin
            if (empty_s) begin
              state_s = ST_ERR;
              done_s  = 1'b1;
              err_s   = 1'b1;
            end else begin
              state_s    = ST_READ;
              mem_req_s  = 1'b1;
              mem_we_s   = 1'b0;
              mem_addr_s = sp_r;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          state_s   = ST_DONE;
          sp_s      = sp_dec_s;
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          done_s    = 1'b1;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          state_s   = ST_DONE;
          sp_s      = sp_inc_s;
          rd_data_s = mem_rdata;
          mem_req_s = 1'b0;
          done_s    = 1'b1;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: begin
        state_s   = ST_IDLE;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
      end
    endcase
  end

  // State, SP and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      sp_r        <= SP_INIT;
      rd_data_r   <= {W{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {W{1'b0}};
      mem_wdata_r <= {W{1'b0}};
    end else begin
      state_r     <= state_s;
      sp_r        <= sp_s;
      rd_data_r   <= rd_data_s;
      done_r      <= done_s;
      err_r       <= err_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign cmd_ready = (state_r == ST_IDLE);
  assign done      = done_r;
  assign err       = err_r;
  assign rd_data   = rd_data_r;
  assign sp        = sp_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule
